// File: rtl/imm_pkg.sv
// Shared immediate-format definitions: type codes used by the encoder and the
// sign extender, the default output-buffer depth, and a sign-range helper.
package imm_pkg;

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_J = 3'd4;
  localparam logic [2:0] TYPE_U = 3'd5;

  localparam int DEPTH_DEFAULT = 2;

  // True when v[31:msb] are all equal, i.e. v fits a (msb+1)-bit signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result bus of the immediate encoder.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// producer holds its payload stable while valid=1 and ready=0.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ext_sel;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cod;
  logic        err;

  modport master (
    output in_valid, ext_sel, base, imm, out_ready,
    input  in_ready, out_valid, cod, err
  );

  modport slave (
    input  in_valid, ext_sel, base, imm, out_ready,
    output in_ready, out_valid, cod, err
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational packer: writes an immediate into the instruction word fields.
// Define IMM_RANGE_CHECK_EN to also flag immediates the format cannot represent.
module imm_pack
  import imm_pkg::*;
(
  input  logic [3:0]  ext_sel,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] cod,
  output logic        err
);

  logic type_err;

  always_comb begin
    cod      = base;
    type_err = 1'b0;
    case (ext_sel[2:0])
      TYPE_R: ;
      TYPE_I: cod[31:20] = imm[11:0];
      TYPE_S: begin
        cod[31:25] = imm[11:5];
        cod[11:7]  = imm[4:0];
      end
      TYPE_B: begin
        cod[31]    = imm[12];
        cod[30:25] = imm[10:5];
        cod[11:8]  = imm[4:1];
        cod[7]     = imm[11];
      end
      // JALR shares the J code from the control unit but uses I layout
      TYPE_J: begin
        if (ext_sel[3]) begin
          cod[31:20] = imm[11:0];
        end else begin
          cod[31]    = imm[20];
          cod[30:21] = imm[10:1];
          cod[20]    = imm[11];
          cod[19:12] = imm[19:12];
        end
      end
      TYPE_U: cod[31:12] = imm[31:12];
      default: type_err = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic rng_err;

  always_comb begin
    rng_err = 1'b0;
    case (ext_sel[2:0])
      TYPE_I, TYPE_S: rng_err = !fits_signed(imm, 11);
      TYPE_B:         rng_err = imm[0] || !fits_signed(imm, 12);
      TYPE_J:         rng_err = ext_sel[3] ? !fits_signed(imm, 11)
                                           : (imm[0] || !fits_signed(imm, 20));
      TYPE_U:         rng_err = (imm[11:0] != 12'h0);
      default:        rng_err = 1'b0;
    endcase
  end

  assign err = type_err | rng_err;
`else
  assign err = type_err;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs accepted requests and queues the results in a
// DEPTH-entry FIFO; also keeps a saturating count of errored accepts.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
)
(
  input  logic         clock,
  input  logic         reset,
  imm_encoder_if.slave bus,
  output logic [7:0]   err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_cod [DEPTH];
  logic          mem_err [DEPTH];
  logic [31:0]   pk_cod;
  logic          pk_err;
  logic          push;
  logic          pop;

  imm_pack u_pack (
    .ext_sel (bus.ext_sel),
    .base    (bus.base),
    .imm     (bus.imm),
    .cod     (pk_cod),
    .err     (pk_err)
  );

  // Ready looks only at the registered count, so a same-cycle pop never
  // opens a full FIFO.
  assign bus.in_ready  = !reset && (count != FULL);
  assign bus.out_valid = (count != '0);
  assign bus.cod       = bus.out_valid ? mem_cod[rd_ptr] : 32'h0;
  assign bus.err       = bus.out_valid ? mem_err[rd_ptr] : 1'b0;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_cod[wr_ptr] <= pk_cod;
      mem_err[wr_ptr] <= pk_err;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= 8'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && pk_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus random traffic
// against a queue-based model. Honors IMM_RANGE_CHECK_EN when defined.
module tb_imm_encoder;

  localparam int DEPTH = 2;

  logic       clock;
  logic       reset;
  logic [7:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  int          exp_ecnt = 0;
  bit          armed    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the format tables; range limits as signed ranges.
  function automatic logic [32:0] ref_enc(input logic [3:0] sel, input logic [31:0] b,
                                          input logic [31:0] i);
    logic [31:0] c;
    logic        terr;
    logic        rerr;
    int          s;
    c    = b;
    terr = 1'b0;
    rerr = 1'b0;
    s    = $signed(i);
    if (sel[2:0] == 3'd1 || (sel[2:0] == 3'd4 && sel[3])) begin
      c[31:20] = i[11:0];
      rerr     = !(s >= -2048 && s <= 2047);
    end else if (sel[2:0] == 3'd2) begin
      c[31:25] = i[11:5];
      c[11:7]  = i[4:0];
      rerr     = !(s >= -2048 && s <= 2047);
    end else if (sel[2:0] == 3'd3) begin
      c[31] = i[12]; c[30:25] = i[10:5]; c[11:8] = i[4:1]; c[7] = i[11];
      rerr  = i[0] || !(s >= -4096 && s <= 4095);
    end else if (sel[2:0] == 3'd4) begin
      c[31] = i[20]; c[30:21] = i[10:1]; c[20] = i[11]; c[19:12] = i[19:12];
      rerr  = i[0] || !(s >= -(1 << 20) && s < (1 << 20));
    end else if (sel[2:0] == 3'd5) begin
      c[31:12] = i[31:12];
      rerr     = (i % 4096) != 0;
    end else if (sel[2:0] >= 3'd6) begin
      terr = 1'b1;
    end
`ifdef IMM_RANGE_CHECK_EN
    return {terr | rerr, c};
`else
    return {terr, c};
`endif
  endfunction

  // ---------------- model: advances on each rising edge ----------------
  always @(posedge clock) begin
    bit acc;
    bit pp;
    logic [32:0] e;
    if (reset) begin
      exp_q.delete();
      exp_ecnt = 0;
      armed    = 1;
    end else if (armed) begin
      acc = bus.in_valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() != 0) && bus.out_ready;
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        e = ref_enc(bus.ext_sel, bus.base, bus.imm);
        exp_q.push_back(e);
        if (e[32] && exp_ecnt < 255) exp_ecnt++;
      end
    end
  end

  // ---------------- compare: every falling edge once armed ----------------
  always @(negedge clock) begin
    if (armed) begin
      check("in_ready", 64'(bus.in_ready), 64'(!reset && (exp_q.size() < DEPTH)));
      check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check("err_count", 64'(err_count), 64'(exp_ecnt));
      if (exp_q.size() != 0) begin
        check("cod", 64'(bus.cod), 64'(exp_q[0][31:0]));
        check("err", 64'(bus.err), 64'(exp_q[0][32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] sel, input logic [31:0] b,
                       input logic [31:0] i, input logic ordy);
    bus.in_valid  = v;
    bus.ext_sel   = sel;
    bus.base      = b;
    bus.imm       = i;
    bus.out_ready = ordy;
    step();
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 4'd0, 32'h0, 32'h0, ordy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r_imm;
    logic        exp_rc_err;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ext_sel   = 4'd0;
    bus.base      = 32'h0;
    bus.imm       = 32'h0;
    bus.out_ready = 1'b0;
    step();
    step();
    @(negedge clock);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_cod", 64'(bus.cod), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);

    // Pin the model to the worked examples.
    check("model_I", 64'(ref_enc(4'd1, 32'h00000093, 32'hFFFFFFFF)), 64'({1'b0, 32'hFFF00093}));
    check("model_S", 64'(ref_enc(4'd2, 32'h0020A023, 32'd8)), 64'({1'b0, 32'h0020A423}));
    check("model_B", 64'(ref_enc(4'd3, 32'h00000063, 32'd16)), 64'({1'b0, 32'h00000863}));
    check("model_J", 64'(ref_enc(4'd4, 32'h000000EF, 32'h800)), 64'({1'b0, 32'h001000EF}));
    check("model_U", 64'(ref_enc(4'd5, 32'h00000037, 32'h12345000)), 64'({1'b0, 32'h12345037}));

    // I-type, one cycle after accept
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;
    drive(1'b1, 4'd1, 32'h00000093, 32'hFFFFFFFF, 1'b0);
    @(negedge clock);
    check("I_valid", 64'(bus.out_valid), 64'd1);
    check("I_cod", 64'(bus.cod), 64'h00000000FFF00093);
    check("I_err", 64'(bus.err), 64'd0);
    idle(1'b1);

    // S then B back to back with consumer ready
    drive(1'b1, 4'd2, 32'h0020A023, 32'd8, 1'b1);
    @(negedge clock);
    check("S_cod", 64'(bus.cod), 64'h000000000020A423);
    drive(1'b1, 4'd3, 32'h00000063, 32'd16, 1'b1);
    @(negedge clock);
    check("B_cod", 64'(bus.cod), 64'h0000000000000863);
    idle(1'b1);

    // J and U with consumer stalled: full after two, order kept
    drive(1'b1, 4'd4, 32'h000000EF, 32'h800, 1'b0);
    drive(1'b1, 4'd5, 32'h00000037, 32'h12345000, 1'b0);
    @(negedge clock);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("J_cod_held", 64'(bus.cod), 64'h00000000001000EF);
    idle(1'b0);
    @(negedge clock);
    check("J_cod_stable", 64'(bus.cod), 64'h00000000001000EF);
    idle(1'b1);
    @(negedge clock);
    check("U_cod", 64'(bus.cod), 64'h0000000012345037);
    idle(1'b1);
    @(negedge clock);
    check("drained", 64'(bus.out_valid), 64'd0);

    // Out-of-range I immediate: truncated pack, err only with range check
`ifdef IMM_RANGE_CHECK_EN
    exp_rc_err = 1'b1;
`else
    exp_rc_err = 1'b0;
`endif
    drive(1'b1, 4'd1, 32'h00000093, 32'h800, 1'b0);
    @(negedge clock);
    check("rc_cod", 64'(bus.cod), 64'h0000000080000093);
    check("rc_err", 64'(bus.err), 64'(exp_rc_err));
    check("rc_err_count", 64'(err_count), 64'(exp_rc_err));
    idle(1'b1);

    // Type 7 x300: err every time, counter saturates
    for (int k = 0; k < 300; k++) drive(1'b1, 4'd7, $urandom, $urandom, 1'b1);
    @(negedge clock);
    check("sat_err", 64'(bus.err), 64'd1);
    check("sat_err_count", 64'(err_count), 64'd255);
    idle(1'b1);
    idle(1'b1);

    // Reset with two entries buffered
    drive(1'b1, 4'd1, $urandom, $urandom, 1'b0);
    drive(1'b1, 4'd7, $urandom, $urandom, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 3))
        0:       r_imm = $urandom;
        1:       r_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2:       r_imm = $urandom & 32'hFFFF_F000;
        default: r_imm = 32'($urandom_range(0, 4_000_000)) - 32'd2_000_000;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom, r_imm,
            1'($urandom_range(0, 2) != 0));
    end
    reset = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
    @(negedge clock);
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
